// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter slice.
package i2s_pkg;

  localparam int I2S_MODE_I2S = 0;
  localparam int I2S_MODE_LJ  = 1;

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } tx_state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2s_tx_fifo_if.sv
// Stereo sample handshake between the audio pipeline (master) and the transmitter (slave).
interface i2s_tx_fifo_if #(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_left,
    output s_right,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_left,
    input  s_right,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO; pointers carry one extra wrap bit so level is a plain difference.
module i2s_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/i2s_tx_fifo.sv
// I2S / left-justified stereo transmitter: frame FIFO, BCLK divider and frame serialiser.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MODE       = I2S_MODE_I2S
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  i2s_tx_fifo_if.slave                  s_if,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_data,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PW      = $clog2(FRAME_W);
  localparam int DW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [PW-1:0] LAST_POS = PW'(FRAME_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  generate
    if (DATA_W < 1)             begin : g_bad_data  $error("DATA_W must be at least 1");       end
    if (SLOT_W < DATA_W)        begin : g_bad_slot  $error("SLOT_W must be >= DATA_W");        end
    if (BCLK_DIV < 1)           begin : g_bad_div   $error("BCLK_DIV must be at least 1");     end
    if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH))
                                begin : g_bad_depth $error("FIFO_DEPTH must be a power of two >= 2"); end
  endgenerate

  tx_state_t          state;
  logic [DW-1:0]      div_cnt;
  logic [PW-1:0]      bit_pos;
  logic [FRAME_W-1:0] shreg;
  logic               lj_bit;    // bit for the current position; delayed copy feeds I2S mode

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [2*DATA_W-1:0] rd_frame;

  logic               div_wrap;
  logic               fall_evt;
  logic [PW-1:0]      next_pos;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_word;
  logic [FRAME_W-1:0] src;
  logic [FRAME_W-1:0] shifted;
  logic               cur_bit;

  assign s_if.s_ready = !fifo_full;
  assign push         = s_if.s_valid && !fifo_full;

  i2s_frame_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({s_if.s_left, s_if.s_right}),
    .rd_data (rd_frame),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // A falling event is the cycle whose edge drives BCLK from 1 to 0.
  assign div_wrap    = (div_cnt == DIV_LAST);
  assign fall_evt    = (state == TX_RUN) && div_wrap && i2s_bclk;
  assign next_pos    = (bit_pos == LAST_POS) ? '0 : bit_pos + PW'(1);
  assign frame_start = fall_evt && (next_pos == '0);
  assign pop         = frame_start && enable && !fifo_empty;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    frame_word = '0;
    if (pop) begin
      frame_word[FRAME_W-1 -: DATA_W] = rd_frame[2*DATA_W-1 -: DATA_W];
      frame_word[SLOT_W-1  -: DATA_W] = rd_frame[DATA_W-1:0];
    end
    src     = frame_start ? frame_word : shreg;
    cur_bit = src[FRAME_W-1];
    shifted = {src[FRAME_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= TX_IDLE;
      div_cnt   <= '0;
      bit_pos   <= '0;
      shreg     <= '0;
      lj_bit    <= 1'b0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_data  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          div_cnt <= '0;
          if (enable) begin
            state   <= TX_RUN;
            bit_pos <= LAST_POS;   // first falling event wraps to position 0
          end
        end
        TX_RUN: begin
          div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
          if (div_wrap) i2s_bclk <= !i2s_bclk;
          if (fall_evt) begin
            if (frame_start && !enable) begin
              state     <= TX_IDLE;
              bit_pos   <= '0;
              shreg     <= '0;
              lj_bit    <= 1'b0;
              i2s_lrclk <= 1'b0;
              i2s_data  <= 1'b0;
            end else begin
              bit_pos   <= next_pos;
              shreg     <= shifted;
              lj_bit    <= cur_bit;
              i2s_lrclk <= (next_pos >= PW'(SLOT_W));
              i2s_data  <= (MODE == I2S_MODE_LJ) ? cur_bit : lj_bit;
              if (frame_start && fifo_empty) underrun <= 1'b1;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
